// File: rtl/sha256_pkg.sv
// SHA-256 constants, word type, round functions and miner FSM states.
// Shared by the compression core and the double-hash sequencer.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE, P1, P2, P3, DONE
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f,
                               input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b,
                                input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_core.sv
// Iterative one-block SHA-256 compression: round 0 on the start edge,
// rounds 1..63 next, then one feed-forward add cycle (65 cycles total).
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] cv,
  input  logic [511:0] blk,
  output logic         busy,
  output logic         valid,
  output logic [255:0] digest
);

  word_t       h  [8];
  word_t       v  [8];
  word_t       w  [16];
  word_t       vs [8];
  word_t       ws [16];
  word_t       vn [8];
  word_t       wn [16];
  word_t       kt;
  word_t       t1;
  word_t       t2;
  logic [6:0]  t;
  logic        load;

  assign load  = start && !busy;
  assign valid = busy && (t == 7'd64);

  // One round plus schedule step; on load it works straight from inputs
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      vs[i] = load ? cv[255-32*i -: 32] : v[i];
    end
    for (int i = 0; i < 16; i++) begin
      ws[i] = load ? blk[511-32*i -: 32] : w[i];
    end
    kt = load ? K[0] : K[t[5:0]];
    t1 = vs[7] + bsig1(vs[4]) + ch(vs[4], vs[5], vs[6]) + kt + ws[0];
    t2 = bsig0(vs[0]) + maj(vs[0], vs[1], vs[2]);
    vn[0] = t1 + t2;
    vn[1] = vs[0];
    vn[2] = vs[1];
    vn[3] = vs[2];
    vn[4] = vs[3] + t1;
    vn[5] = vs[4];
    vn[6] = vs[5];
    vn[7] = vs[6];
    for (int i = 0; i < 15; i++) begin
      wn[i] = ws[i+1];
    end
    wn[15] = ssig1(ws[14]) + ws[9] + ssig0(ws[1]) + ws[0];
  end

  // Feed-forward sum, meaningful while valid is high
  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) begin
      digest[255-32*i -: 32] = h[i] + v[i];
    end
  end

  // Round counter, working variables, schedule window, chaining value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      t    <= '0;
      h    <= IV;
      v    <= IV;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      busy <= 1'b1;
      t    <= 7'd1;
      v    <= vn;
      w    <= wn;
      for (int i = 0; i < 8; i++) h[i] <= cv[255-32*i -: 32];
    end else if (busy) begin
      if (t == 7'd64) begin
        busy <= 1'b0;
        t    <= '0;
        for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
      end else begin
        t <= t + 7'd1;
        v <= vn;
        w <= wn;
      end
    end
  end

endmodule

// File: rtl/miner.sv
// Double SHA-256 of an 80-byte header: two header blocks, then the
// padded 32-byte intermediate digest; result held until reset.
module miner
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [639:0] block,
  output logic [255:0] hashed,
  output logic         done
);

  state_t        state;
  state_t        state_n;
  logic          start;
  logic          busy;
  logic          valid;
  logic [255:0]  cv;
  logic [255:0]  digest;
  logic [255:0]  mid;
  logic [255:0]  iv_flat;
  logic [511:0]  msg;

  assign iv_flat = {IV[0], IV[1], IV[2], IV[3],
                    IV[4], IV[5], IV[6], IV[7]};

  sha256_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cv     (cv),
    .blk    (msg),
    .busy   (busy),
    .valid  (valid),
    .digest (digest)
  );

  // Pass sequencing and per-pass padding/chaining selection
  always_comb begin
    state_n = state;
    start   = 1'b0;
    cv      = iv_flat;
    msg     = block[639:128];
    unique case (state)
      IDLE: state_n = P1;
      P1: begin
        start = !busy;
        if (valid) state_n = P2;
      end
      P2: begin
        cv    = mid;
        msg   = {block[127:0], 32'h8000_0000, 288'd0, 64'd640};
        start = !busy;
        if (valid) state_n = P3;
      end
      P3: begin
        msg   = {mid, 32'h8000_0000, 160'd0, 64'd256};
        start = !busy;
        if (valid) state_n = DONE;
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Intermediate digest and sticky result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mid    <= '0;
      hashed <= '0;
      done   <= 1'b0;
    end else if (valid) begin
      if (state == P3) begin
        hashed <= digest;
        done   <= 1'b1;
      end else begin
        mid <= digest;
      end
    end
  end

endmodule

// File: tb/tb_miner.sv
// Bench for miner: software double-SHA-256 model, per-cycle output
// check against elapsed edges, plus a standalone core check.
module tb_miner;

  localparam logic [255:0] IVF =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [639:0] GEN = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };
  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [639:0] block;
  logic [255:0] hashed;
  logic         done;

  logic         c_rst = 1'b0;
  logic         c_start;
  logic [255:0] c_cv;
  logic [511:0] c_blk;
  logic         c_busy;
  logic         c_valid;
  logic [255:0] c_digest;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cnt;
  bit           watch = 1'b0;
  logic [255:0] exp_hash = '0;

  always #5 clk = ~clk;

  miner dut (
    .clk    (clk),
    .rst    (rst),
    .block  (block),
    .hashed (hashed),
    .done   (done)
  );

  sha256_core u_core (
    .clk    (clk),
    .rst    (c_rst),
    .start  (c_start),
    .cv     (c_cv),
    .blk    (c_blk),
    .busy   (c_busy),
    .valid  (c_valid),
    .digest (c_digest)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 of len bytes (len up to 119) with standard padding
  function automatic logic [255:0] sha256(input logic [7:0] m [128],
                                          input int len);
    logic [7:0]  p [128];
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
    logic [63:0] bits;
    int          nb;
    for (int i = 0; i < 128; i++) p[i] = (i < len) ? m[i] : 8'h00;
    p[len] = 8'h80;
    nb = (len + 8) / 64 + 1;
    bits = 64'(len * 8);
    for (int j = 0; j < 8; j++) p[nb*64-1-j] = bits[8*j +: 8];
    h = IVT;
    for (int bk = 0; bk < nb; bk++) begin
      for (int i = 0; i < 16; i++)
        w[i] = {p[bk*64+4*i], p[bk*64+4*i+1],
                p[bk*64+4*i+2], p[bk*64+4*i+3]};
      for (int i = 16; i < 64; i++)
        w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10))
             + w[i-7]
             + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
             + w[i-16];
      {a, b, c, d, e, f, g, hh} = {h[0], h[1], h[2], h[3],
                                   h[4], h[5], h[6], h[7]};
      for (int i = 0; i < 64; i++) begin
        x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25))
           + ((e & f) ^ (~e & g)) + KT[i] + w[i];
        x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + x1;
        d = c; c = b; b = a; a = x1 + x2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr);
    logic [7:0]   m [128];
    logic [255:0] d1;
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    for (int i = 0; i < 80; i++) m[i] = hdr[639-8*i -: 8];
    d1 = sha256(m, 80);
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    for (int i = 0; i < 32; i++) m[i] = d1[255-8*i -: 8];
    return sha256(m, 32);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Rising edges seen since the last reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  // Every cycle: outputs are zero before edge 196, the digest from then on
  always @(negedge clk) begin
    if (watch) begin
      chk("done_cycle", 256'(done), 256'(cnt >= 196));
      chk("hashed_cycle", hashed, (cnt >= 196) ? exp_hash : 256'd0);
    end
  end

  task automatic wait_done(input string nm);
    int lat;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(nm, 256'(lat), 256'd196);
  endtask

  task automatic rand_hdr(output logic [639:0] hv);
    for (int i = 0; i < 20; i++) hv[639-32*i -: 32] = $urandom;
  endtask

  initial begin
    logic [7:0]   m [128];
    logic [639:0] hv;
    int           n;

    block   = GEN;
    c_start = 1'b0;
    c_cv    = '0;
    c_blk   = '0;

    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    m[0] = 8'h61; m[1] = 8'h62; m[2] = 8'h63;
    chk("model_abc", sha256(m, 3), ABC_HASH);
    chk("model_genesis", sha256d(GEN), GEN_HASH);

    // Genesis header, rst low through the first 5 ns
    #1;
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_hashed", hashed, 256'd0);
    exp_hash = sha256d(GEN);
    watch = 1'b1;
    #6 rst = 1'b1;
    wait_done("genesis_latency");
    chk("genesis_hash", hashed, GEN_HASH);

    // Result must hold while the header keeps changing
    repeat (50) begin
      @(negedge clk);
      #2;
      rand_hdr(hv);
      block = hv;
    end
    chk("hold_done", 256'(done), 256'd1);
    chk("hold_hashed", hashed, GEN_HASH);

    // Abort at edge 100, then a full restart
    @(negedge clk);
    #2;
    rst = 1'b0;
    block = GEN;
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_done", 256'(done), 256'd0);
    chk("abort_hashed", hashed, 256'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    wait_done("restart_latency");
    chk("restart_hash", hashed, GEN_HASH);

    // Random headers against the model
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      rst = 1'b0;
      rand_hdr(hv);
      block = hv;
      exp_hash = sha256d(hv);
      @(negedge clk);
      #2;
      rst = 1'b1;
      wait_done("rand_latency");
      repeat (3) @(negedge clk);
    end
    watch = 1'b0;

    // Standalone core: "abc" block from the IV
    @(negedge clk);
    #2;
    c_rst = 1'b1;
    @(negedge clk);
    #2;
    c_cv    = IVF;
    c_blk   = {32'h61626380, 416'd0, 64'd24};
    c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    n = 0;
    while (!c_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Start edge plus 63 round edges; the 65th edge is the add
    chk("core_rounds", 256'(n), 256'd63);
    chk("core_abc", c_digest, ABC_HASH);
    @(posedge clk);
    #1;
    chk("core_idle", 256'(c_busy), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
